pattern_gate_gen: RTL



---
 rtl/pattern_gate_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pattern_gate_gen.sv
// -----------------------------------------------------------------------------
// pattern_gate_gen
//
// Clocked, restartable multi-channel toggle pattern source with registered
// gate reductions. Each channel toggles every period_i cycles while a run is
// active; a run ends after run_len cycles (or on abort, or never if
// run_len == 0). OR, NOR and XOR reductions of the channel outputs are
// registered one cycle behind ch_out.
//
// Parameters:
//   CH     number of channels
//   CNT_W  width of each half-period field / channel counter
//   RUN_W  width of the run-length counter
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    single-cycle start request, accepted only in IDLE
//   abort    stop the run immediately (wins over start in IDLE)
//   period   packed half-periods, channel i at [i*CNT_W +: CNT_W]
//   run_len  run length in cycles, 0 = free-run until abort
//   ch_out   channel outputs
//   or_out   registered OR of ch_out
//   nor_out  registered NOR of ch_out
//   xor_out  registered XOR (parity) of ch_out
//   busy     high while in RUN
//   done     one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module pattern_gate_gen #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int RUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CH*CNT_W-1:0]   period,
  input  logic [RUN_W-1:0]      run_len,
  output logic [CH-1:0]         ch_out,
  output logic                  or_out,
  output logic                  nor_out,
  output logic                  xor_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_e                     state_q, state_d;
  logic [CH-1:0]              ch_q, ch_d;
  logic [CH-1:0][CNT_W-1:0]   per_q, per_d;
  logic [CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]           run_q, run_d;
  logic                       or_q, nor_q, xor_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ch_d    = ch_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    run_d   = run_q;

    unique case (state_q)
      ST_IDLE: begin
        ch_d = '0;
        // abort in the same cycle as start cancels the request
        if (start && !abort) begin
          state_d = ST_RUN;
          per_d   = period;
          cnt_d   = period;
          run_d   = run_len;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // abort overrides both channel toggles and the run-end transition
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          for (int i = 0; i < CH; i++) begin
            if (per_q[i] == '0) begin
              ch_d[i] = 1'b0;
            end else if (cnt_q[i] == CNT_ONE) begin
              // reload at 1 so the counter never passes through 0
              ch_d[i]  = ~ch_q[i];
              cnt_d[i] = per_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          // run counter of 0 means free-run: left untouched
          if (run_q != '0) begin
            run_d = run_q - RUN_ONE;
            if (run_q == RUN_ONE) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      // NOTE: the latched periods and counters are a handful of flops, not a
      // RAM, so they are reset to give a fully defined post-reset state.
      per_q   <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  // Gate reductions of the registered channel value: one cycle behind ch_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q  <= 1'b0;
      nor_q <= 1'b1;
      xor_q <= 1'b0;
    end else begin
      or_q  <= |ch_q;
      nor_q <= ~|ch_q;
      xor_q <= ^ch_q;
    end
  end

  assign ch_out  = ch_q;
  assign or_out  = or_q;
  assign nor_out = nor_q;
  assign xor_out = xor_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule
